// File: rtl/axi_burst_mem_slave.sv
// AXI burst memory slave: independent write (AW/W/B) and read (AR/R) FSMs
// over a word-wide byte-enabled storage array. Every beat is full width.
module axi_burst_mem_slave #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int MEM_WORDS = 1024
) (
    input  logic                aclk_i,
    input  logic                aresetn_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic [7:0]          awlen_i,
    input  logic [1:0]          awburst_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wlast_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic [7:0]          arlen_i,
    input  logic [1:0]          arburst_i,
    input  logic                arvalid_i,
    output logic                arready_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o,
    output logic                rvalid_o,
    input  logic                rready_i
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int MW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // Reserved burst type, or WRAP with a length other than 2/4/8/16 beats.
    function automatic logic bad_burst(input logic [7:0] len, input logic [1:0] burst);
        return (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a >> OFF} < (ADDR_W + 1)'(MEM_WORDS));
    endfunction

    function automatic logic [MW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return MW'(a >> OFF);
    endfunction

    // WRAP keeps the upper bits of the window and lets the low bits roll over.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'((32'(len) + 32'd1) * 32'(BYTES) - 32'd1);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + ADDR_W'(BYTES)) & mask);
            default: return a + ADDR_W'(BYTES);
        endcase
    endfunction

    // ---------------- write channel ----------------
    w_state_e          w_state_q, w_state_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic              w_err_q, w_err_d;
    logic              w_last_beat, mem_we;

    assign w_last_beat = (w_cnt_q == w_len_q);

    // Write FSM next state; error flag is sticky for the whole burst.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (awvalid_i) begin
                w_addr_d  = awaddr_i & ALIGN_MASK;
                w_len_d   = awlen_i;
                w_burst_d = awburst_i;
                w_cnt_d   = 8'd0;
                w_err_d   = bad_burst(awlen_i, awburst_i);
                w_state_d = W_DATA;
            end
            W_DATA: if (wvalid_i) begin
                mem_we   = !bad_burst(w_len_q, w_burst_q) && in_range(w_addr_q);
                if (!in_range(w_addr_q) || (wlast_i != w_last_beat))
                    w_err_d = 1'b1;
                w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
                w_cnt_d  = w_cnt_q + 8'd1;
                if (w_last_beat)
                    w_state_d = W_RESP;
            end
            W_RESP: if (bready_i) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    // Byte-enabled storage write; storage is never reset.
    always_ff @(posedge aclk_i) begin
        if (mem_we)
            for (int b = 0; b < BYTES; b++)
                if (wstrb_i[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end

    // Ready outputs are gated by reset so they read 0 while it is held.
    assign awready_o = (w_state_q == W_IDLE) && aresetn_i;
    assign wready_o  = (w_state_q == W_DATA);
    assign bvalid_o  = (w_state_q == W_RESP);
    assign bresp_o   = (bvalid_o && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read channel ----------------
    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic              fetch_en;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;

    // Read FSM next state; a fetch happens on AR accept and on each non-final R handshake.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        fetch_en  = 1'b0;
        case (r_state_q)
            R_IDLE: if (arvalid_i) begin
                r_addr_d  = araddr_i & ALIGN_MASK;
                r_len_d   = arlen_i;
                r_burst_d = arburst_i;
                r_cnt_d   = 8'd0;
                fetch_en  = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: if (rready_i) begin
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_addr_d = next_addr(r_addr_q, r_len_q, r_burst_q);
                    r_cnt_d  = r_cnt_q + 8'd1;
                    fetch_en = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // Registered read beat; holds while stalled, sees pre-write data on a same-cycle write.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else if (fetch_en) begin
            rlast_q <= (r_cnt_d == r_len_d);
            if (bad_burst(r_len_d, r_burst_d) || !in_range(r_addr_d)) begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end else begin
                rdata_q <= mem[word_idx(r_addr_d)];
                rresp_q <= RESP_OKAY;
            end
        end
    end

    assign arready_o = (r_state_q == R_IDLE) && aresetn_i;
    assign rvalid_o  = (r_state_q == R_DATA);
    assign rlast_o   = rlast_q && rvalid_o;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed bench for axi_burst_mem_slave (DATA_W=32, MEM_WORDS=1024).
module tb_axi_burst_mem_slave;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSV = 2'b11;
    localparam logic [1:0] OK = 2'b00, ERR = 2'b10;

    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [15:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [1:0]  awburst = '0, arburst = '0;
    logic        awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rlast, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int checks = 0, failures = 0;

    logic [31:0] got_d [16];
    logic [1:0]  got_r [16];
    logic        got_l [16];
    int          rd_cycles;

    axi_burst_mem_slave #(.DATA_W(32), .ADDR_W(16), .MEM_WORDS(1024)) dut (
        .aclk_i(aclk), .aresetn_i(aresetn),
        .awaddr_i(awaddr), .awlen_i(awlen), .awburst_i(awburst),
        .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
        .wvalid_i(wvalid), .wready_o(wready),
        .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .araddr_i(araddr), .arlen_i(arlen), .arburst_i(arburst),
        .arvalid_i(arvalid), .arready_o(arready),
        .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
        .rvalid_o(rvalid), .rready_i(rready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [31:0] base;
        logic [3:0]  strb;
        int          wlast_at;
        logic [1:0]  exp_bresp;
        logic [3:0][31:0] exp_d;
        logic [3:0][1:0]  exp_r;
    } vec_t;

    function automatic vec_t W(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b,
                               input logic [31:0] base, input logic [3:0] s, input int wl,
                               input logic [1:0] er);
        vec_t v;
        v = '{wr: 1'b1, addr: a, len: l, burst: b, base: base, strb: s, wlast_at: wl,
              exp_bresp: er, exp_d: '0, exp_r: '0};
        return v;
    endfunction

    function automatic vec_t R(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3,
                               input logic [1:0] r0, input logic [1:0] r1,
                               input logic [1:0] r2, input logic [1:0] r3);
        vec_t v;
        v = '{wr: 1'b0, addr: a, len: l, burst: b, base: '0, strb: '0, wlast_at: 0,
              exp_bresp: '0, exp_d: {d3, d2, d1, d0}, exp_r: {r3, r2, r1, r0}};
        return v;
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [31:0] base, input logic [3:0] strb, input int wlast_at,
                            output logic [1:0] resp, output int wcyc);
        int t;
        @(negedge aclk);
        awaddr = a; awlen = len; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        check("aw_handshake", 32'(awready), 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        wcyc = 0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = base + 32'(i); wstrb = strb; wlast = (i == wlast_at); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin @(negedge aclk); t++; wcyc++; end
            if (t == 50) check("w_handshake", 32'(wready), 32'd1);
            @(negedge aclk);
            wcyc++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge aclk); t++; end
        check("b_handshake", 32'(bvalid), 32'd1);
        resp = bresp;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input bit rnd);
        int t, n;
        bit stalled;
        logic [31:0] hd;
        logic [1:0]  hr;
        logic        hl;
        @(negedge aclk);
        araddr = a; arlen = len; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        check("ar_handshake", 32'(arready), 32'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        check("rd_latency", 32'(rvalid), 32'd1);
        n = 0; t = 0; stalled = 0; hd = '0; hr = '0; hl = 1'b0;
        while (n < int'(len) + 1 && t < 1000) begin
            rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled && rvalid) begin
                check("r_stable_data", rdata, hd);
                check("r_stable_ctl", {29'd0, rlast, rresp}, {29'd0, hl, hr});
            end
            if (rvalid && rready) begin
                got_d[n] = rdata; got_r[n] = rresp; got_l[n] = rlast;
                n++; stalled = 0;
            end else begin
                stalled = rvalid; hd = rdata; hr = rresp; hl = rlast;
            end
            @(negedge aclk);
            t++;
        end
        rready = 1'b0;
        rd_cycles = t;
        check("r_beat_count", 32'(n), 32'(len) + 32'd1);
    endtask

    localparam int NV = 23;
    vec_t vec [NV];

    initial begin
        logic [1:0] resp;
        int wc;

        vec[0]  = W(16'h0100, 8'd3, INCR,  32'hA0, 4'hF, 3, OK);
        vec[1]  = R(16'h0100, 8'd3, INCR,  32'hA0, 32'hA1, 32'hA2, 32'hA3, OK, OK, OK, OK);
        vec[2]  = R(16'h0108, 8'd3, WRAP,  32'hA2, 32'hA3, 32'hA0, 32'hA1, OK, OK, OK, OK);
        vec[3]  = W(16'h0200, 8'd0, FIXED, 32'h12345678, 4'hF, 0, OK);
        vec[4]  = W(16'h0200, 8'd0, FIXED, 32'hFFFFFFFF, 4'h3, 0, OK);
        vec[5]  = R(16'h0200, 8'd0, INCR,  32'h1234FFFF, 0, 0, 0, OK, OK, OK, OK);
        vec[6]  = R(16'h1000, 8'd1, INCR,  0, 0, 0, 0, ERR, ERR, OK, OK);
        vec[7]  = W(16'h0300, 8'd3, INCR,  32'hB0, 4'hF, 1, ERR);
        vec[8]  = R(16'h0300, 8'd3, INCR,  32'hB0, 32'hB1, 32'hB2, 32'hB3, OK, OK, OK, OK);
        vec[9]  = W(16'h0400, 8'd1, INCR,  32'hC0, 4'hF, 5, ERR);
        vec[10] = W(16'h0300, 8'd2, WRAP,  32'hD0, 4'hF, 2, ERR);
        vec[11] = R(16'h0300, 8'd3, INCR,  32'hB0, 32'hB1, 32'hB2, 32'hB3, OK, OK, OK, OK);
        vec[12] = R(16'h0300, 8'd2, WRAP,  0, 0, 0, 0, ERR, ERR, ERR, OK);
        vec[13] = R(16'h0100, 8'd1, RSV,   0, 0, 0, 0, ERR, ERR, OK, OK);
        vec[14] = W(16'h0500, 8'd2, FIXED, 32'hE0, 4'hF, 2, OK);
        vec[15] = R(16'h0500, 8'd1, FIXED, 32'hE2, 32'hE2, 0, 0, OK, OK, OK, OK);
        vec[16] = W(16'h0FFC, 8'd1, INCR,  32'hF0, 4'hF, 1, ERR);
        vec[17] = R(16'h0FFC, 8'd1, INCR,  32'hF0, 0, 0, 0, OK, ERR, OK, OK);
        vec[18] = R(16'h0102, 8'd1, INCR,  32'hA0, 32'hA1, 0, 0, OK, OK, OK, OK);
        vec[19] = W(16'h060C, 8'd1, WRAP,  32'h70, 4'hF, 1, OK);
        vec[20] = R(16'h0608, 8'd1, INCR,  32'h71, 32'h70, 0, 0, OK, OK, OK, OK);
        vec[21] = R(16'h0400, 8'd1, INCR,  32'hC0, 32'hC1, 0, 0, OK, OK, OK, OK);
        vec[22] = W(16'h0800, 8'd0, INCR,  32'h11111111, 4'hF, 0, OK);

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_ready", {28'd0, awready, wready, arready, bvalid}, 32'd0);
        check("rst_rvalid_rlast", {30'd0, rvalid, rlast}, 32'd0);
        check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;
        #1;
        check("post_rst_ready", {30'd0, awready, arready}, 32'd3);

        // Table vectors
        for (int k = 0; k < NV; k++) begin
            if (vec[k].wr) begin
                do_write(vec[k].addr, vec[k].len, vec[k].burst, vec[k].base, vec[k].strb,
                         vec[k].wlast_at, resp, wc);
                check($sformatf("v%0d_bresp", k), 32'(resp), 32'(vec[k].exp_bresp));
            end else begin
                do_read(vec[k].addr, vec[k].len, vec[k].burst, 1'b0);
                for (int b = 0; b <= int'(vec[k].len); b++) begin
                    check($sformatf("v%0d_b%0d_rdata", k, b), got_d[b], vec[k].exp_d[b]);
                    check($sformatf("v%0d_b%0d_rresp", k, b), 32'(got_r[b]), 32'(vec[k].exp_r[b]));
                    check($sformatf("v%0d_b%0d_rlast", k, b), 32'(got_l[b]),
                          32'(b == int'(vec[k].len)));
                end
                check($sformatf("v%0d_rd_cycles", k), 32'(rd_cycles), 32'(vec[k].len) + 32'd1);
            end
        end

        // 16-beat write at full rate, then read with random rready stalls
        do_write(16'h0700, 8'd15, INCR, 32'h5000, 4'hF, 15, resp, wc);
        check("w16_bresp", 32'(resp), 32'(OK));
        check("w16_cycles", 32'(wc), 32'd16);
        do_read(16'h0700, 8'd15, INCR, 1'b1);
        for (int b = 0; b < 16; b++) begin
            check($sformatf("r16_b%0d_rdata", b), got_d[b], 32'h5000 + 32'(b));
            check($sformatf("r16_b%0d_rlast", b), 32'(got_l[b]), 32'(b == 15));
        end

        // Same-cycle write beat and read fetch of one word returns the old data
        @(negedge aclk);
        awaddr = 16'h0800; awlen = 8'd0; awburst = INCR; awvalid = 1'b1;
        check("raw_awready", 32'(awready), 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        wdata = 32'h22222222; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        araddr = 16'h0800; arlen = 8'd0; arburst = INCR; arvalid = 1'b1;
        check("raw_wr_ar_ready", {30'd0, wready, arready}, 32'd3);
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        check("raw_rvalid", 32'(rvalid), 32'd1);
        check("raw_old_data", rdata, 32'h11111111);
        check("raw_bvalid", 32'(bvalid), 32'd1);
        rready = 1'b1; bready = 1'b1;
        @(negedge aclk);
        rready = 1'b0; bready = 1'b0;
        do_read(16'h0800, 8'd0, INCR, 1'b0);
        check("raw_new_data", got_d[0], 32'h22222222);

        // Reset in the middle of a read burst
        @(negedge aclk);
        araddr = 16'h0700; arlen = 8'd15; arburst = INCR; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        repeat (2) @(negedge aclk);
        check("mid_rvalid_before", 32'(rvalid), 32'd1);
        aresetn = 1'b0; rready = 1'b0;
        #1;
        check("mid_rst_outputs", {28'd0, rvalid, rlast, arready, awready}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("mid_post_rvalid", 32'(rvalid), 32'd0);
        check("mid_post_arready", 32'(arready), 32'd1);
        do_read(16'h0700, 8'd0, INCR, 1'b0);
        check("mid_storage_kept", got_d[0], 32'h5000);
        do_read(16'h0100, 8'd0, INCR, 1'b0);
        check("mid_storage_kept2", got_d[0], 32'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
